// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade control front-end: PS/2 scan codes and
// the bit layout of the exported control vector.
package arcade_input_pkg;

    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] KEY_FIRE0  = 8'h29;
    localparam logic [7:0] KEY_FIRE1  = 8'h14;
    localparam logic [7:0] KEY_FIRE2  = 8'h11;
    localparam logic [7:0] KEY_START1 = 8'h05;
    localparam logic [7:0] KEY_START2 = 8'h06;
    localparam logic [7:0] KEY_COIN   = 8'h04;
    localparam logic [7:0] KEY_F0     = 8'hF0;
    localparam logic [7:0] KEY_E0     = 8'hE0;

    typedef enum logic [2:0] {
        CtrlUp, CtrlDown, CtrlLeft, CtrlRight, CtrlFire, CtrlStart1, CtrlStart2, CtrlCoin
    } ctrl_e;

    // Bit position of a field in {coin, start2, start1, fire[], right, left, down, up}.
    function automatic int unsigned ctrl_idx(ctrl_e name, int unsigned num_fire);
        case (name)
            CtrlUp:     return 0;
            CtrlDown:   return 1;
            CtrlLeft:   return 2;
            CtrlRight:  return 3;
            CtrlFire:   return 4;
            CtrlStart1: return 4 + num_fire;
            CtrlStart2: return 5 + num_fire;
            CtrlCoin:   return 6 + num_fire;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [7:0] fire_code(int unsigned i);
        case (i)
            0:       return KEY_FIRE0;
            1:       return KEY_FIRE1;
            default: return KEY_FIRE2;
        endcase
    endfunction

endpackage

// File: rtl/input_autofire.sv
// Per-button autofire: while enabled and held, output starts high and
// toggles every AfHalf cycles; otherwise the raw button passes through.
module input_autofire #(
    parameter int unsigned AfHalf = 400000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic af_en,
    input  logic fire_raw,
    output logic fire_out
);

    localparam int unsigned CntW = (AfHalf > 1) ? $clog2(AfHalf) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!af_en || !fire_raw) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CntW'(AfHalf - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // phase 0 is the high half so a fresh press fires immediately.
    assign fire_out = fire_raw & (~af_en | ~phase_q);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade control front-end: PS/2 key latches ORed with joysticks, orientation
// remap, per-button autofire and coin stretching into a registered control word.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_JOY  = 2,
    parameter int unsigned NUM_FIRE = 1,
    parameter int unsigned AF_HALF  = 400000,
    parameter int unsigned COIN_MIN = 1200000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [64:0]           ps2_key,
    input  logic [16*NUM_JOY-1:0] joy,
    input  logic                  rotate,
    input  logic [NUM_FIRE-1:0]   af_en,
    output logic [NUM_FIRE+6:0]   ctrl,
    output logic                  key_any
);

    localparam int unsigned CtrlW     = NUM_FIRE + 7;
    localparam int unsigned CoinW     = $clog2(COIN_MIN + 1);
    localparam int unsigned IdxFire   = ctrl_idx(CtrlFire, NUM_FIRE);
    localparam int unsigned IdxStart1 = ctrl_idx(CtrlStart1, NUM_FIRE);
    localparam int unsigned IdxStart2 = ctrl_idx(CtrlStart2, NUM_FIRE);
    localparam int unsigned IdxCoin   = ctrl_idx(CtrlCoin, NUM_FIRE);

    logic                pressed, extended, key_event;
    logic [8:0]          code;
    logic                old_toggle_q;
    logic [3:0]          dir_q, dir_d;    // {right, left, down, up}
    logic [NUM_FIRE-1:0] fire_q, fire_d;
    logic [2:0]          sys_q, sys_d;    // {coin, start2, start1}

    always_comb begin
        pressed   = ps2_key[15:8] != KEY_F0;
        extended  = pressed ? (ps2_key[15:8] == KEY_E0) : (ps2_key[23:16] == KEY_E0);
        code      = (|ps2_key[63:24]) ? 9'h000 : {extended, ps2_key[7:0]};
        key_event = ps2_key[64] != old_toggle_q;
    end

    always_comb begin
        dir_d  = dir_q;
        fire_d = fire_q;
        sys_d  = sys_q;
        if (key_event) begin
            // Directions accept both the keypad and the extended arrow codes.
            if (code[7:0] == KEY_UP)    dir_d[0] = pressed;
            if (code[7:0] == KEY_DOWN)  dir_d[1] = pressed;
            if (code[7:0] == KEY_LEFT)  dir_d[2] = pressed;
            if (code[7:0] == KEY_RIGHT) dir_d[3] = pressed;
            for (int unsigned i = 0; i < NUM_FIRE; i++) begin
                if (code == {1'b0, fire_code(i)}) fire_d[i] = pressed;
            end
            if (code == {1'b0, KEY_START1}) sys_d[0] = pressed;
            if (code == {1'b0, KEY_START2}) sys_d[1] = pressed;
            if (code == {1'b0, KEY_COIN})   sys_d[2] = pressed;
        end
    end

    logic [15:0]         joy_or;
    logic [3:0]          raw_dir, rot_dir;
    logic [NUM_FIRE-1:0] raw_fire, af_fire;
    logic                raw_start1, raw_start2, raw_coin;
    logic                unused_joy;

    always_comb begin
        joy_or = '0;
        for (int unsigned j = 0; j < NUM_JOY; j++) begin
            joy_or = joy_or | joy[16*j +: 16];
        end
        raw_dir    = dir_q | {joy_or[0], joy_or[1], joy_or[2], joy_or[3]};
        raw_fire   = fire_q | joy_or[4 +: NUM_FIRE];
        raw_start1 = sys_q[0] | joy_or[8];
        raw_start2 = sys_q[1] | joy_or[9];
        raw_coin   = sys_q[2] | joy_or[10];
        // Rotated: up<-left, down<-right, left<-down, right<-up.
        rot_dir    = rotate ? {raw_dir[0], raw_dir[1], raw_dir[3], raw_dir[2]} : raw_dir;
    end

    assign unused_joy = ^{joy_or[15:11], joy_or[7:4]};

    for (genvar g = 0; g < NUM_FIRE; g++) begin : g_af
        input_autofire #(
            .AfHalf (AF_HALF)
        ) u_af (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .af_en    (af_en[g]),
            .fire_raw (raw_fire[g]),
            .fire_out (af_fire[g])
        );
    end

    logic [CoinW-1:0] coin_cnt_q, coin_cnt_d;
    logic             coin_prev_q, coin_out;

    always_comb begin
        if (raw_coin && !coin_prev_q) begin
            coin_cnt_d = CoinW'(COIN_MIN);
        end else if (coin_cnt_q != '0) begin
            coin_cnt_d = coin_cnt_q - 1'b1;
        end else begin
            coin_cnt_d = '0;
        end
        // Using the next count makes a one-cycle pulse last exactly COIN_MIN cycles.
        coin_out = raw_coin | (coin_cnt_d != '0);
    end

    logic [CtrlW-1:0] ctrl_d, ctrl_q;
    logic             key_any_q;

    always_comb begin
        ctrl_d                          = '0;
        ctrl_d[3:0]                     = rot_dir;
        ctrl_d[IdxFire +: NUM_FIRE]     = af_fire;
        ctrl_d[IdxStart1]               = raw_start1;
        ctrl_d[IdxStart2]               = raw_start2;
        ctrl_d[IdxCoin]                 = coin_out;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_toggle_q <= ps2_key[64];
            dir_q        <= '0;
            fire_q       <= '0;
            sys_q        <= '0;
            coin_cnt_q   <= '0;
            coin_prev_q  <= 1'b0;
            ctrl_q       <= '0;
            key_any_q    <= 1'b0;
        end else begin
            old_toggle_q <= ps2_key[64];
            dir_q        <= dir_d;
            fire_q       <= fire_d;
            sys_q        <= sys_d;
            coin_cnt_q   <= coin_cnt_d;
            coin_prev_q  <= raw_coin;
            ctrl_q       <= ctrl_d;
            key_any_q    <= |{dir_q, fire_q, sys_q};
        end
    end

    assign ctrl    = ctrl_q;
    assign key_any = key_any_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper (2 joysticks, 2 fire buttons,
// AF_HALF=4, COIN_MIN=10) with hand-computed expectations.
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [64:0] ps2_key;
    logic [31:0] joy;
    logic        rotate;
    logic [1:0]  af_en;
    logic [8:0]  ctrl;
    logic        key_any;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // ctrl layout: 0 up, 1 down, 2 left, 3 right, 4 fire0, 5 fire1, 6 start1, 7 start2, 8 coin
    arcade_input_mapper #(
        .NUM_JOY  (2),
        .NUM_FIRE (2),
        .AF_HALF  (4),
        .COIN_MIN (10)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .joy     (joy),
        .rotate  (rotate),
        .af_en   (af_en),
        .ctrl    (ctrl),
        .key_any (key_any)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_key(input logic [63:0] word);
        ps2_key = {~ps2_key[64], word};
        step();
    endtask

    logic [11:0] af_pat;

    initial begin
        reset   = 1'b1;
        ps2_key = {1'b1, 64'h0};
        joy     = '0;
        rotate  = 1'b0;
        af_en   = 2'b00;
        af_pat  = 12'b1111_0000_1111;
        step(3);
        check_eq("reset_ctrl", 32'(ctrl), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("post_reset_ctrl", 32'(ctrl), 32'h0);
        end
        check_eq("post_reset_key_any", 32'(key_any), 32'h0);

        // Extended up press, then break sequence E0 F0 75.
        send_key(64'h0000_0000_0000_E075);
        check_eq("up_latency_edge1", 32'(ctrl[0]), 32'h0);
        step();
        check_eq("up_pressed", 32'(ctrl), 32'h001);
        check_eq("up_key_any", 32'(key_any), 32'h1);
        send_key(64'h0000_0000_00E0_F075);
        step();
        check_eq("up_released", 32'(ctrl), 32'h000);
        check_eq("up_rel_key_any", 32'(key_any), 32'h0);

        // Rotation: left key -> up, joystick up -> right.
        rotate = 1'b1;
        send_key(64'h0000_0000_0000_006B);
        step();
        check_eq("rot_left_to_up", 32'(ctrl[3:0]), 32'h1);
        joy[3] = 1'b1;
        step();
        check_eq("rot_joy_up_to_right", 32'(ctrl[3:0]), 32'h9);
        send_key(64'h0000_0000_0000_F06B);
        joy    = '0;
        rotate = 1'b0;
        step();
        check_eq("rot_cleared", 32'(ctrl), 32'h000);
        joy[16+1] = 1'b1;
        step();
        check_eq("joy1_left_norot", 32'(ctrl), 32'h004);
        joy = '0;
        step();

        // start1 via key.
        send_key(64'h0000_0000_0000_0005);
        step();
        check_eq("start1_key", 32'(ctrl), 32'h040);
        send_key(64'h0000_0000_0000_F005);
        step();
        check_eq("start1_release", 32'(ctrl), 32'h000);

        // Autofire on fire1 (LCtrl), fire0 steady from joystick.
        af_en  = 2'b10;
        joy[4] = 1'b1;
        send_key(64'h0000_0000_0000_0014);
        check_eq("af_edge0", 32'(ctrl[5:4]), 32'h1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check_eq("af_pattern", 32'(ctrl[5:4]), 32'({af_pat[12-k], 1'b1}));
        end
        joy    = '0;
        af_en  = 2'b00;
        send_key(64'h0000_0000_0000_F014);
        step();
        check_eq("af_released", 32'(ctrl), 32'h000);

        // Coin: one-cycle pulse on joystick 1 -> 10 cycles high.
        for (int e = 0; e <= 12; e++) begin
            if (e == 0) joy[16+10] = 1'b1;
            step();
            joy[16+10] = 1'b0;
            check_eq("coin_single", 32'(ctrl[8]), 32'(e <= 9));
        end
        // Re-pulse five cycles in reloads the stretcher.
        for (int e = 0; e <= 16; e++) begin
            if (e == 0 || e == 5) joy[16+10] = 1'b1;
            step();
            joy[16+10] = 1'b0;
            check_eq("coin_reload", 32'(ctrl[8]), 32'(e <= 14));
        end

        // PrtScr-style word: upper bytes nonzero masks the code.
        send_key(64'h0000_0001_0000_0075);
        step();
        check_eq("prtscr_ctrl", 32'(ctrl), 32'h000);
        check_eq("prtscr_key_any", 32'(key_any), 32'h0);

        // Reset in the middle of autofire, with a simultaneous key press.
        af_en = 2'b01;
        send_key(64'h0000_0000_0000_0029);
        step();
        check_eq("af0_running", 32'(ctrl[4]), 32'h1);
        step();
        reset = 1'b1;
        send_key(64'h0000_0000_0000_0075);
        check_eq("mid_reset_ctrl", 32'(ctrl), 32'h000);
        check_eq("mid_reset_key_any", 32'(key_any), 32'h0);
        reset = 1'b0;
        step(3);
        check_eq("after_reset_ctrl", 32'(ctrl), 32'h000);
        check_eq("after_reset_key_any", 32'(key_any), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
